// File: rtl/faims_gen_p.sv
// FAIMS waveform generator with a multi-phase coil driver and double-buffered parameters.
// Parameter changes are held pending and only reach the generator between periods.
module faims_gen_p #(
  parameter int CW  = 16,
  parameter int SW  = 8,
  parameter int NPH = 2
) (
  input  logic           CLK,
  input  logic           i_resetN,
  input  logic           i_enable,
  input  logic           i_load,
  input  logic [CW-1:0]  i_period,
  input  logic [CW-1:0]  i_pulse,
  input  logic [CW-1:0]  i_work,
  input  logic [SW-1:0]  i_skips,
  input  logic           i_invert,
  output logic           o_faimsUp,
  output logic           o_faimsDown,
  output logic [NPH-1:0] o_coilU,
  output logic [NPH-1:0] o_coilD,
  output logic           o_periodStart,
  output logic           o_pending
);

  localparam int PW = (NPH > 1) ? $clog2(NPH) : 1;
  localparam logic [PW-1:0] LAST_PH = PW'(NPH - 1);

  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] pulse;
    logic [CW-1:0] work;
    logic [SW-1:0] skips;
    logic          invert;
  } paramSet_t;

  paramSet_t     pendSet_r, pendSet_s;
  paramSet_t     actSet_r, actSet_s;
  logic          pendFlag_r, pendFlag_s;
  logic          running_r, running_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [SW-1:0] skipCnt_r, skipCnt_s;
  logic [PW-1:0] phase_r, phase_s;
  logic          wrap_s, apply_s;

  logic           faimsUp_s, faimsDown_s, periodStart_s, upRaw_s;
  logic [NPH-1:0] coilU_s, coilD_s;
  logic [CW:0]    cntW_s, workW_s, work2_s;

  // Next-state: parameter buffering, run control, period/skip/phase sequencing
  always_comb begin
    pendSet_s  = pendSet_r;
    pendFlag_s = pendFlag_r;
    actSet_s   = actSet_r;
    running_s  = running_r;
    cnt_s      = cnt_r;
    skipCnt_s  = skipCnt_r;
    phase_s    = phase_r;

    wrap_s  = running_r && (cnt_r == (actSet_r.period - CW'(1)));
    apply_s = pendFlag_r && (!running_r || wrap_s);

    if (apply_s) begin
      actSet_s = pendSet_r;
    end else begin
      actSet_s = actSet_r;
    end

    // A load on the apply edge replaces pending after the old set moved over
    if (i_load) begin
      pendSet_s  = '{period: i_period, pulse: i_pulse, work: i_work,
                     skips: i_skips, invert: i_invert};
      pendFlag_s = 1'b1;
    end else if (apply_s) begin
      pendFlag_s = 1'b0;
    end else begin
      pendFlag_s = pendFlag_r;
    end

    if (!i_enable || (actSet_s.period < CW'(2))) begin
      running_s = 1'b0;
      cnt_s     = '0;
      skipCnt_s = '0;
      phase_s   = '0;
    end else if (!running_r) begin
      running_s = 1'b1;
      cnt_s     = '0;
      skipCnt_s = '0;
      phase_s   = '0;
    end else if (wrap_s) begin
      cnt_s = '0;
      if (skipCnt_r >= actSet_r.skips) begin
        skipCnt_s = '0;
      end else begin
        skipCnt_s = skipCnt_r + SW'(1);
      end
      // Phase steps after each driving period, whatever follows it
      if (skipCnt_r == '0) begin
        phase_s = (phase_r == LAST_PH) ? '0 : phase_r + PW'(1);
      end else begin
        phase_s = phase_r;
      end
    end else begin
      cnt_s = cnt_r + CW'(1);
    end
  end

  // Output decode of the state being loaded this edge
  always_comb begin
    faimsUp_s     = 1'b0;
    faimsDown_s   = 1'b0;
    periodStart_s = 1'b0;
    coilU_s       = '0;
    coilD_s       = '0;
    upRaw_s       = (cnt_s < actSet_s.pulse);
    cntW_s        = {1'b0, cnt_s};
    workW_s       = {1'b0, actSet_s.work};
    work2_s       = {actSet_s.work, 1'b0};
    if (running_s) begin
      faimsUp_s     = upRaw_s ^ actSet_s.invert;
      faimsDown_s   = ~faimsUp_s;
      periodStart_s = (cnt_s == '0);
      if (skipCnt_s == '0) begin
        coilU_s[phase_s] = (cntW_s < workW_s);
        coilD_s[phase_s] = (cntW_s >= workW_s) && (cntW_s < work2_s);
      end else begin
        coilU_s = '0;
        coilD_s = '0;
      end
    end else begin
      faimsUp_s   = 1'b0;
      faimsDown_s = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge i_resetN) begin
    if (!i_resetN) begin
      pendSet_r     <= '0;
      actSet_r      <= '0;
      pendFlag_r    <= 1'b0;
      running_r     <= 1'b0;
      cnt_r         <= '0;
      skipCnt_r     <= '0;
      phase_r       <= '0;
      o_faimsUp     <= 1'b0;
      o_faimsDown   <= 1'b0;
      o_coilU       <= '0;
      o_coilD       <= '0;
      o_periodStart <= 1'b0;
      o_pending     <= 1'b0;
    end else begin
      pendSet_r     <= pendSet_s;
      actSet_r      <= actSet_s;
      pendFlag_r    <= pendFlag_s;
      running_r     <= running_s;
      cnt_r         <= cnt_s;
      skipCnt_r     <= skipCnt_s;
      phase_r       <= phase_s;
      o_faimsUp     <= faimsUp_s;
      o_faimsDown   <= faimsDown_s;
      o_coilU       <= coilU_s;
      o_coilD       <= coilD_s;
      o_periodStart <= periodStart_s;
      o_pending     <= pendFlag_s;
    end
  end

endmodule

// File: tb/tb_faims_gen_p.sv
// Directed self-checking bench for faims_gen_p (CW=16, SW=8, NPH=2).
module tb_faims_gen_p;
  logic        CLK = 1'b0;
  logic        i_resetN, i_enable, i_load, i_invert;
  logic [15:0] i_period, i_pulse, i_work;
  logic [7:0]  i_skips;
  logic        o_faimsUp, o_faimsDown, o_periodStart, o_pending;
  logic [1:0]  o_coilU, o_coilD;
  int          passCnt = 0;
  int          totalCnt = 0;

  faims_gen_p dut (
    .CLK(CLK), .i_resetN(i_resetN), .i_enable(i_enable), .i_load(i_load),
    .i_period(i_period), .i_pulse(i_pulse), .i_work(i_work), .i_skips(i_skips),
    .i_invert(i_invert), .o_faimsUp(o_faimsUp), .o_faimsDown(o_faimsDown),
    .o_coilU(o_coilU), .o_coilD(o_coilD), .o_periodStart(o_periodStart),
    .o_pending(o_pending)
  );

  always #5 CLK = ~CLK;

  // {up, down, coilU[1:0], coilD[1:0], periodStart}
  function automatic logic [6:0] obs();
    return {o_faimsUp, o_faimsDown, o_coilU, o_coilD, o_periodStart};
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic loadP(input int p, input int pu, input int w, input int s, input logic inv);
    i_period = 16'(p); i_pulse = 16'(pu); i_work = 16'(w); i_skips = 8'(s); i_invert = inv;
    i_load = 1'b1;
    tick();
    i_load = 1'b0;
  endtask

  task automatic restart(input int p, input int pu, input int w, input int s, input logic inv);
    i_enable = 1'b0;
    tick();
    loadP(p, pu, w, s, inv);
    i_enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    i_resetN = 1'b0; i_enable = 1'b0; i_load = 1'b0; i_invert = 1'b0;
    i_period = 16'd0; i_pulse = 16'd0; i_work = 16'd0; i_skips = 8'd0;
    #12;
    totalCnt++;
    if ({obs(), o_pending} !== 8'h00)
      $display("FAIL reset_outputs got=%b exp=%b", {obs(), o_pending}, 8'h00);
    else passCnt++;
    @(negedge CLK);
    i_resetN = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [6:0] e;
    logic [1:0] m;
    i_enable = 1'b0;
    tick();
    loadP(10, 5, 3, 0, 1'b0);
    totalCnt++;
    if ({obs(), o_pending} !== 8'b0000_0001)
      $display("FAIL basic_pending got=%b exp=%b", {obs(), o_pending}, 8'b0000_0001);
    else passCnt++;
    i_enable = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      int c;
      c = k % 10;
      m = ((k / 10) % 2 == 1) ? 2'b10 : 2'b01;
      e = {c < 5, c >= 5, (c < 3) ? m : 2'b00, (c >= 3 && c < 6) ? m : 2'b00, c == 0};
      totalCnt++;
      if (obs() !== e) $display("FAIL basic k=%0d got=%b exp=%b", k, obs(), e);
      else passCnt++;
      tick();
    end
  endtask

  task automatic test_skips();
    logic [6:0] e;
    logic [1:0] m;
    restart(10, 5, 3, 2, 1'b0);
    for (int k = 0; k < 70; k++) begin
      int c, p;
      c = k % 10;
      p = k / 10;
      m = (p % 3 != 0) ? 2'b00 : (((p / 3) % 2 == 1) ? 2'b10 : 2'b01);
      e = {c < 5, c >= 5, (c < 3) ? m : 2'b00, (c >= 3 && c < 6) ? m : 2'b00, c == 0};
      totalCnt++;
      if (obs() !== e) $display("FAIL skips k=%0d got=%b exp=%b", k, obs(), e);
      else passCnt++;
      tick();
    end
  endtask

  task automatic test_pending_apply();
    logic [6:0] e;
    restart(10, 5, 3, 0, 1'b0);
    repeat (4) tick();
    loadP(20, 5, 3, 0, 1'b0);
    for (int c = 5; c < 10; c++) begin
      totalCnt++;
      if ({o_pending, o_periodStart} !== 2'b10)
        $display("FAIL pend_hold c=%0d got=%b exp=%b", c, {o_pending, o_periodStart}, 2'b10);
      else passCnt++;
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      e = {c < 5, c >= 5, (c < 3) ? 2'b10 : 2'b00, (c >= 3 && c < 6) ? 2'b10 : 2'b00, c == 0};
      totalCnt++;
      if ({obs(), o_pending} !== {e, 1'b0})
        $display("FAIL pend_new c=%0d got=%b exp=%b", c, {obs(), o_pending}, {e, 1'b0});
      else passCnt++;
      tick();
    end
    totalCnt++;
    if ({o_periodStart, o_coilU} !== 3'b101)
      $display("FAIL pend_len got=%b exp=%b", {o_periodStart, o_coilU}, 3'b101);
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    restart(10, 5, 3, 0, 1'b0);
    repeat (4) tick();
    loadP(6, 2, 1, 0, 1'b0);
    repeat (4) tick();
    loadP(20, 5, 3, 0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      totalCnt++;
      if ({o_pending, o_periodStart, o_faimsUp} !== {1'b1, c == 0, c < 2})
        $display("FAIL b2b_old c=%0d got=%b exp=%b", c,
                 {o_pending, o_periodStart, o_faimsUp}, {1'b1, c == 0, c < 2});
      else passCnt++;
      tick();
    end
    for (int c = 0; c < 21; c++) begin
      int cc;
      cc = c % 20;
      totalCnt++;
      if ({o_pending, o_periodStart, o_faimsUp} !== {1'b0, cc == 0, cc < 5})
        $display("FAIL b2b_new c=%0d got=%b exp=%b", c,
                 {o_pending, o_periodStart, o_faimsUp}, {1'b0, cc == 0, cc < 5});
      else passCnt++;
      tick();
    end
  endtask

  task automatic test_faims();
    int pu[3] = '{12, 0, 5};
    logic iv[3] = '{1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      restart(10, pu[t], 3, 0, iv[t]);
      for (int c = 0; c < 10; c++) begin
        logic u;
        u = (c < pu[t]) ^ iv[t];
        totalCnt++;
        if ({o_faimsUp, o_faimsDown} !== {u, ~u})
          $display("FAIL faims t=%0d c=%0d got=%b exp=%b", t, c, {o_faimsUp, o_faimsDown}, {u, ~u});
        else passCnt++;
        tick();
      end
    end
  endtask

  task automatic test_work_trunc();
    restart(10, 5, 6, 0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      logic [3:0] e;
      e = {(c < 6) ? 2'b01 : 2'b00, (c >= 6) ? 2'b01 : 2'b00};
      totalCnt++;
      if ({o_coilU, o_coilD} !== e) $display("FAIL work6 c=%0d got=%b exp=%b", c, {o_coilU, o_coilD}, e);
      else passCnt++;
      tick();
    end
    restart(1, 5, 3, 0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      totalCnt++;
      if (obs() !== 7'd0) $display("FAIL period1 c=%0d got=%b exp=%b", c, obs(), 7'd0);
      else passCnt++;
      tick();
    end
  endtask

  task automatic test_disable();
    restart(10, 5, 3, 0, 1'b0);
    repeat (12) tick();
    totalCnt++;
    if (o_coilU !== 2'b10) $display("FAIL dis_pre got=%b exp=%b", o_coilU, 2'b10);
    else passCnt++;
    i_enable = 1'b0;
    tick();
    totalCnt++;
    if (obs() !== 7'd0) $display("FAIL dis_off got=%b exp=%b", obs(), 7'd0);
    else passCnt++;
    i_enable = 1'b1;
    tick();
    totalCnt++;
    if (obs() !== 7'b1001001) $display("FAIL dis_restart got=%b exp=%b", obs(), 7'b1001001);
    else passCnt++;
  endtask

  task automatic test_reset_mid();
    restart(10, 5, 3, 0, 1'b0);
    repeat (7) tick();
    totalCnt++;
    if (obs() !== 7'b0100000) $display("FAIL rst_pre got=%b exp=%b", obs(), 7'b0100000);
    else passCnt++;
    #2 i_resetN = 1'b0;
    #1;
    totalCnt++;
    if ({obs(), o_pending} !== 8'h00) $display("FAIL rst_async got=%b exp=%b", {obs(), o_pending}, 8'h00);
    else passCnt++;
    @(negedge CLK);
    i_resetN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      totalCnt++;
      if ({obs(), o_pending} !== 8'h00) $display("FAIL rst_idle c=%0d got=%b exp=%b", c, {obs(), o_pending}, 8'h00);
      else passCnt++;
    end
    loadP(10, 5, 3, 0, 1'b0);
    totalCnt++;
    if ({obs(), o_pending} !== 8'h01) $display("FAIL rst_load got=%b exp=%b", {obs(), o_pending}, 8'h01);
    else passCnt++;
    tick();
    totalCnt++;
    if (obs() !== 7'b1001001) $display("FAIL rst_resume got=%b exp=%b", obs(), 7'b1001001);
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skips();
    test_pending_apply();
    test_back_to_back();
    test_faims();
    test_work_trunc();
    test_disable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
